// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU matrix-memory loader path.
// Holds the loader FSM encoding, the default frame sync marker, the base
// addresses of the four RAM banks and a checksum accumulate helper.
package npu_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_LO = 3'd1,
        ADDR_HI = 3'd2,
        LEN_LO  = 3'd3,
        LEN_HI  = 3'd4,
        DATA    = 3'd5,
        CSUM    = 3'd6
    } loader_state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [15:0] BANK0_BASE = 16'h0000;
    localparam logic [15:0] BANK1_BASE = 16'h4000;
    localparam logic [15:0] BANK2_BASE = 16'h8000;
    localparam logic [15:0] BANK3_BASE = 16'hC000;

    // Running XOR over the header and payload bytes of a frame.
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/mem_byte_loader.sv
// Framed byte-stream loader feeding the banked matrix RAM byte-write port.
// Frame: SYNC_BYTE, addr lo, addr hi, len lo, len hi, payload[len], and a
// trailing XOR checksum byte when MEM_LOADER_CHECKSUM_EN is defined.
// Each accepted payload byte becomes one registered write one cycle later.
module mem_byte_loader
    import npu_mem_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              mem_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] bytes_written
);

    loader_state_t     state;
    loader_state_t     state_next;
    logic              ready_en;
    logic              accept;
    logic [7:0]        addr_lo_byte;
    logic [7:0]        len_lo_byte;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] remaining;
    logic              len_zero;
    logic              last_byte;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_acc;
`endif

    // The payload stage is throttled by the memory side; every other stage
    // always takes a byte. ready_en holds the port closed for the first cycle
    // after reset release.
    assign in_ready  = ready_en & ((state == DATA) ? mem_ready : 1'b1);
    // abort takes priority: a byte offered together with abort is dropped.
    assign accept    = in_valid & in_ready & ~abort;
    assign busy      = (state != IDLE);
    assign len_zero  = ({in_data, len_lo_byte} == 16'h0000);
    assign last_byte = (remaining == ADDR_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: one header byte per stage, payload until count is exhausted.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        state_next = ADDR_LO;
                    end else begin
                        state_next = IDLE;
                    end
                end
                ADDR_LO: state_next = ADDR_HI;
                ADDR_HI: state_next = LEN_LO;
                LEN_LO:  state_next = LEN_HI;
                LEN_HI: begin
                    if (len_zero) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (last_byte) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = DATA;
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                CSUM:    state_next = IDLE;
`endif
                default: state_next = IDLE;
            endcase
        end else begin
            state_next = state;
        end
    end

    // Datapath: header capture, address/count tracking, registered write port and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en      <= 1'b0;
            addr_lo_byte  <= 8'h00;
            len_lo_byte   <= 8'h00;
            addr_cnt      <= '0;
            remaining     <= '0;
            mem_addr      <= '0;
            mem_data      <= 8'h00;
            mem_we        <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            bytes_written <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_acc      <= 8'h00;
`endif
        end else begin
            ready_en <= 1'b1;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                if (state != IDLE) begin
                    err <= 1'b1;
                end else begin
                    err <= err;
                end
            end else if (accept) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            err <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                            csum_acc <= 8'h00;
`endif
                        end else begin
                            err <= err;
                        end
                    end
                    ADDR_LO: begin
                        addr_lo_byte <= in_data;
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_next(csum_acc, in_data);
`endif
                    end
                    ADDR_HI: begin
                        addr_cnt <= ADDR_W'({in_data, addr_lo_byte});
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_next(csum_acc, in_data);
`endif
                    end
                    LEN_LO: begin
                        len_lo_byte <= in_data;
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_next(csum_acc, in_data);
`endif
                    end
                    LEN_HI: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_next(csum_acc, in_data);
`endif
                        if (len_zero) begin
                            err <= 1'b1;
                        end else begin
                            remaining     <= ADDR_W'({in_data, len_lo_byte});
                            bytes_written <= '0;
                        end
                    end
                    DATA: begin
                        mem_we        <= 1'b1;
                        mem_addr      <= addr_cnt;
                        mem_data      <= in_data;
                        addr_cnt      <= addr_cnt + ADDR_W'(1);
                        remaining     <= remaining - ADDR_W'(1);
                        bytes_written <= bytes_written + ADDR_W'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
                        csum_acc <= csum_next(csum_acc, in_data);
`else
                        // Frame completion coincides with the final write.
                        done <= last_byte;
`endif
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    CSUM: begin
                        done <= 1'b1;
                        if (csum_acc != in_data) begin
                            err <= 1'b1;
                        end else begin
                            err <= err;
                        end
                    end
`endif
                    default: begin
                        err <= err;
                    end
                endcase
            end else begin
                err <= err;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_loader.sv
// Scoreboard bench for mem_byte_loader: the stimulus side derives the
// expected write list of each frame from its start address and payload and
// queues it; a monitor pops and compares every write the DUT presents.
module tb_mem_byte_loader;

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_ready = 1'b1;
    logic        abort = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] bytes_written;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;

    mem_byte_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_ready(mem_ready), .abort(abort),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err), .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) done_cnt++;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", {16'h0, mem_addr}, {16'h0, e.addr});
                    chk("write_data", {24'h0, mem_data}, {24'h0, e.data});
                    if (!CSUM_EN) chk("done_with_last", {31'h0, done}, {31'h0, e.last});
                end
            end else if (done && !CSUM_EN) begin
                chk("done_without_write", 32'd1, 32'd0);
            end
        end
    end

    // Offer one byte (called at a negedge) until accepted; optionally jitter mem_ready.
    task automatic send_byte(input logic [7:0] b, input bit rand_ready);
        bit ok = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 100) begin
            mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (in_ready) ok = 1'b1;
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_header(input logic [15:0] a, input logic [15:0] len);
        send_byte(8'hA5, 1'b0);
        chk("err_clear_on_sync", {31'h0, err}, 32'd0);
        send_byte(a[7:0], 1'b0);
        send_byte(a[15:8], 1'b0);
        send_byte(len[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
    endtask

    // Full frame: expected writes are start address plus offset, modulo 2^16.
    task automatic run_frame(input logic [15:0] a, input byte_q_t p, input bit rand_ready, input bit corrupt);
        int          n;
        int          d0;
        logic [15:0] len;
        logic [7:0]  cs;
        n   = p.size();
        len = 16'(n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{addr: a + 16'(i), data: p[i], last: (i == n - 1)});
        d0 = done_cnt;
        send_header(a, len);
        cs = a[7:0] ^ a[15:8] ^ len[7:0] ^ len[15:8];
        for (int i = 0; i < n; i++) begin
            send_byte(p[i], rand_ready);
            cs = cs ^ p[i];
        end
        if (CSUM_EN) send_byte(corrupt ? (cs ^ 8'h01) : cs, 1'b0);
        for (int k = 0; k < 20 && done_cnt == d0; k++) @(negedge clk);
        @(negedge clk);
        chk("done_pulse_count", 32'(done_cnt - d0), 32'd1);
        chk("bytes_written", {16'h0, bytes_written}, {16'h0, len});
        chk("err_after_frame", {31'h0, err}, {31'h0, CSUM_EN && corrupt});
        chk("busy_after_frame", {31'h0, busy}, 32'd0);
        chk("addr_hold", {16'h0, mem_addr}, {16'h0, a + len - 16'd1});
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        byte_q_t     p;
        logic [15:0] a;
        int          d0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
        chk("rst_bytes_written", {16'h0, bytes_written}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_first_cycle", {31'h0, in_ready}, 32'd0);
        @(negedge clk);
        chk("in_ready_idle", {31'h0, in_ready}, 32'd1);

        // Bank 1 frame, back-to-back payload.
        p = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(16'h4000, p, 1'b0, 1'b0);

        // Garbage before sync, then a frame that wraps past 0xFFFF.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        chk("garbage_ignored", {31'h0, busy}, 32'd0);
        p = {8'hAA, 8'hBB, 8'hCC};
        run_frame(16'hFFFE, p, 1'b0, 1'b0);

        // Throttled payload with an odd start address.
        p = {8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E, 8'hAF};
        run_frame(16'h8001, p, 1'b1, 1'b0);

        // Zero length: error, no writes, back to IDLE.
        send_header(16'h1234, 16'h0000);
        @(negedge clk);
        chk("zero_len_err", {31'h0, err}, 32'd1);
        chk("zero_len_busy", {31'h0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("zero_len_no_write", 32'(exp_q.size()), 32'd0);

        // Checksum example frame (also a plain frame in the default build).
        p = {8'h01, 8'h02};
        run_frame(16'h0010, p, 1'b0, 1'b0);
        run_frame(16'h0010, p, 1'b0, 1'b1);

        // Abort after 2 of 8 payload bytes; the byte offered with abort is dropped.
        a = 16'($urandom_range(0, 65535));
        p = {};
        for (int i = 0; i < 2; i++) p.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 2; i++) exp_q.push_back('{addr: a + 16'(i), data: p[i], last: 1'b0});
        d0 = done_cnt;
        send_header(a, 16'd8);
        send_byte(p[0], 1'b0);
        send_byte(p[1], 1'b0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_err", {31'h0, err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_writes", 32'(exp_q.size()), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_we_low", {31'h0, mem_we}, 32'd0);

        // Randomized frames with stray bytes and mem_ready jitter.
        for (int f = 0; f < 10; f++) begin
            logic [7:0] g;
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h5A;
                send_byte(g, 1'b0);
            end
            a = 16'($urandom_range(0, 65535));
            p = {};
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) p.push_back(8'($urandom_range(0, 255)));
            run_frame(a, p, 1'b1, bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a frame abandons it.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h12, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_bytes_written", {16'h0, bytes_written}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p = {8'hDE, 8'hAD};
        run_frame(16'hC000, p, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
